// File: rtl/updown_counter.sv
// Parameterised up/down counter with wrap, saturate or one-shot behaviour at
// the count bounds, plus synchronous clear and clamped load.
module updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MIN_VALUE = 0,
  parameter int MAX_VALUE = 255,
  parameter int STEP      = 1,
  parameter int MODE      = 0
) (
  input  logic             clk_i,
  input  logic             a_rst_n_i,
  input  logic             enable_i,
  input  logic             dir_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] value_o,
  output logic             tc_o,
  output logic             done_o,
  output logic             at_min_o,
  output logic             at_max_o
);

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_ONESHOT = 2;

  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH:0]   MIN_EXT  = (WIDTH+1)'(MIN_VALUE);
  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);

  if (!(MIN_VALUE >= 0 && MIN_VALUE < MAX_VALUE &&
        64'(MAX_VALUE) < (64'sd1 <<< WIDTH) &&
        STEP >= 1 && STEP <= (MAX_VALUE - MIN_VALUE) &&
        (MODE == MODE_WRAP || MODE == MODE_SAT || MODE == MODE_ONESHOT))) begin : g_param_check
    $error("updown_counter: illegal parameter combination");
  end

  logic [WIDTH-1:0] value_r;
  logic             tc_r;
  logic             done_r;

  logic [WIDTH:0]   value_ext_s;
  logic [WIDTH:0]   load_ext_s;
  logic             boundary_s;
  logic [WIDTH-1:0] clamp_s;
  logic [WIDTH-1:0] value_nxt_s;
  logic             tc_nxt_s;
  logic             done_nxt_s;

  // Next-state selection: clear beats load beats an enabled step.
  always_comb begin
    value_ext_s = {1'b0, value_r};
    load_ext_s  = {1'b0, load_value_i};
    // Widened compares so value + STEP cannot overflow before the test.
    if (dir_i) begin
      boundary_s = (value_ext_s + STEP_EXT) > MAX_EXT;
    end else begin
      boundary_s = value_ext_s < (MIN_EXT + STEP_EXT);
    end

    if (load_ext_s < MIN_EXT) begin
      clamp_s = MIN_W;
    end else if (load_ext_s > MAX_EXT) begin
      clamp_s = MAX_W;
    end else begin
      clamp_s = load_value_i;
    end

    value_nxt_s = value_r;
    tc_nxt_s    = 1'b0;
    done_nxt_s  = done_r;

    if (clear_i) begin
      value_nxt_s = MIN_W;
      done_nxt_s  = 1'b0;
    end else if (load_i) begin
      value_nxt_s = clamp_s;
      done_nxt_s  = 1'b0;
    end else if (enable_i && !done_r) begin
      if (boundary_s) begin
        tc_nxt_s = 1'b1;
        case (MODE)
          MODE_WRAP:    value_nxt_s = dir_i ? MIN_W : MAX_W;
          MODE_SAT:     value_nxt_s = dir_i ? MAX_W : MIN_W;
          MODE_ONESHOT: begin
            value_nxt_s = dir_i ? MAX_W : MIN_W;
            done_nxt_s  = 1'b1;
          end
          default:      value_nxt_s = value_r;
        endcase
      end else if (dir_i) begin
        value_nxt_s = value_r + STEP_W;
      end else begin
        value_nxt_s = value_r - STEP_W;
      end
    end else begin
      value_nxt_s = value_r;
    end
  end

  // Counter state registers with asynchronous reset to the lower bound.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      value_r <= MIN_W;
      tc_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      value_r <= value_nxt_s;
      tc_r    <= tc_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign value_o  = value_r;
  assign tc_o     = tc_r;
  assign done_o   = done_r;
  assign at_min_o = (value_r == MIN_W);
  assign at_max_o = (value_r == MAX_W);

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench: four counter configurations driven in parallel and
// compared against a plain-arithmetic reference model, plus directed tables.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, dir = 1'b0, clear = 1'b0, load = 1'b0;
  logic [7:0] load_value = 8'd0;

  logic [7:0] val [4];
  logic       tc [4], done [4], amin [4], amax [4];

  int errors = 0;
  int checks = 0;

  // Configurations: A default wrap, B saturate 10..100/7, C one-shot 0..15, D wrap 10..100/7
  int p_min  [4] = '{0, 10, 0, 10};
  int p_max  [4] = '{255, 100, 15, 100};
  int p_step [4] = '{1, 7, 1, 7};
  int p_mode [4] = '{0, 1, 2, 0};

  int m_v [4];
  bit m_tc [4], m_done [4];

  always #5 clk = ~clk;

  updown_counter dut_a (.clk_i(clk), .a_rst_n_i(rst_n), .enable_i(enable), .dir_i(dir),
    .clear_i(clear), .load_i(load), .load_value_i(load_value), .value_o(val[0]),
    .tc_o(tc[0]), .done_o(done[0]), .at_min_o(amin[0]), .at_max_o(amax[0]));
  updown_counter #(.MIN_VALUE(10), .MAX_VALUE(100), .STEP(7), .MODE(1)) dut_b (
    .clk_i(clk), .a_rst_n_i(rst_n), .enable_i(enable), .dir_i(dir),
    .clear_i(clear), .load_i(load), .load_value_i(load_value), .value_o(val[1]),
    .tc_o(tc[1]), .done_o(done[1]), .at_min_o(amin[1]), .at_max_o(amax[1]));
  updown_counter #(.MIN_VALUE(0), .MAX_VALUE(15), .STEP(1), .MODE(2)) dut_c (
    .clk_i(clk), .a_rst_n_i(rst_n), .enable_i(enable), .dir_i(dir),
    .clear_i(clear), .load_i(load), .load_value_i(load_value), .value_o(val[2]),
    .tc_o(tc[2]), .done_o(done[2]), .at_min_o(amin[2]), .at_max_o(amax[2]));
  updown_counter #(.MIN_VALUE(10), .MAX_VALUE(100), .STEP(7), .MODE(0)) dut_d (
    .clk_i(clk), .a_rst_n_i(rst_n), .enable_i(enable), .dir_i(dir),
    .clear_i(clear), .load_i(load), .load_value_i(load_value), .value_o(val[3]),
    .tc_o(tc[3]), .done_o(done[3]), .at_min_o(amin[3]), .at_max_o(amax[3]));

  task automatic chk(input string name, input int dut, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0d exp=%0d at %0t", name, dut, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_v[i] = p_min[i]; m_tc[i] = 1'b0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      m_tc[i] = 1'b0;
      if (clear) begin
        m_v[i] = p_min[i]; m_done[i] = 1'b0;
      end else if (load) begin
        m_v[i] = (int'(load_value) < p_min[i]) ? p_min[i] :
                 (int'(load_value) > p_max[i]) ? p_max[i] : int'(load_value);
        m_done[i] = 1'b0;
      end else if (enable && !m_done[i]) begin
        int nv;
        nv = dir ? m_v[i] + p_step[i] : m_v[i] - p_step[i];
        if (nv > p_max[i] || nv < p_min[i]) begin
          m_tc[i] = 1'b1;
          if (p_mode[i] == 0) m_v[i] = dir ? p_min[i] : p_max[i];
          else                m_v[i] = dir ? p_max[i] : p_min[i];
          if (p_mode[i] == 2) m_done[i] = 1'b1;
        end else begin
          m_v[i] = nv;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk("value", i, int'(val[i]), m_v[i]);
      chk("tc", i, int'(tc[i]), int'(m_tc[i]));
      chk("done", i, int'(done[i]), int'(m_done[i]));
      chk("at_min", i, int'(amin[i]), int'(m_v[i] == p_min[i]));
      chk("at_max", i, int'(amax[i]), int'(m_v[i] == p_max[i]));
    end
  endtask

  // One clock: inputs already applied; model follows the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit c, input bit l, input logic [7:0] lv, input bit e, input bit d);
    clear = c; load = l; load_value = lv; enable = e; dir = d;
  endtask

  typedef struct {
    bit         clr, ld;
    logic [7:0] lv;
    bit         en, dir;
    int         exp_v;
    bit         exp_tc;
  } vec_t;

  vec_t tbl [13];
  int   tc_pulses;
  int   tc_at;

  initial begin
    // Expectations for the saturating 10..100 step-7 instance
    tbl[0]  = '{1'b0, 1'b1, 8'd95,  1'b0, 1'b0, 95,  1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 100, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 100, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 100, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 100, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'd3,   1'b0, 1'b0, 10,  1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 10,  1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 17,  1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'd50,  1'b1, 1'b1, 10,  1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'd50,  1'b1, 1'b1, 50,  1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 57,  1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 50,  1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 43,  1'b0};

    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].dir);
      cycle();
      chk("tbl_value", 1, int'(val[1]), tbl[i].exp_v);
      chk("tbl_tc", 1, int'(tc[1]), int'(tbl[i].exp_tc));
    end

    // One-shot countdown from 2 on instance C
    drive(1'b0, 1'b1, 8'd2, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0); cycle();
    chk("os_v1", 2, int'(val[2]), 1);
    cycle();
    chk("os_v0", 2, int'(val[2]), 0);
    chk("os_notdone", 2, int'(done[2]), 0);
    cycle();
    chk("os_done", 2, int'(done[2]), 1);
    chk("os_tc", 2, int'(tc[2]), 1);
    chk("os_hold", 2, int'(val[2]), 0);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1); cycle(); cycle();
    chk("os_ignored", 2, int'(val[2]), 0);
    chk("os_tc_quiet", 2, int'(tc[2]), 0);
    drive(1'b0, 1'b1, 8'd5, 1'b0, 1'b0); cycle();
    chk("os_reload_v", 2, int'(val[2]), 5);
    chk("os_reload_done", 2, int'(done[2]), 0);

    // 256 up-steps on the default instance wrap once
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    tc_pulses = 0; tc_at = -1;
    for (int i = 0; i < 256; i++) begin
      cycle();
      if (i == 254) chk("wrap_255", 0, int'(val[0]), 255);
      if (tc[0]) begin tc_pulses++; tc_at = i; end
    end
    chk("wrap_value", 0, int'(val[0]), 0);
    chk("wrap_pulses", 0, tc_pulses, 1);
    chk("wrap_pulse_at", 0, tc_at, 255);
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1); cycle();
    chk("wrap_tc_drop", 0, int'(tc[0]), 0);

    // Asynchronous reset between edges while counting
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    cycle(); cycle();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("areset_a", 0, int'(val[0]), 0);
    chk("areset_b", 1, int'(val[1]), 10);
    #1 rst_n = 1'b1;
    cycle();
    chk("resume_a", 0, int'(val[0]), 1);
    chk("resume_b", 1, int'(val[1]), 17);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
            8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
